// File: rtl/hook_renderer.sv
// hook_renderer
// Draws NUM_HOOKS fishing hooks and their animated lines over the VGA raster.
// Hook positions arrive in 0.1 px units and are latched once per frame, so
// every frame is drawn with one consistent set of positions and line states.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   valid             active-video qualifier for h_cnt / v_cnt
//   h_cnt, v_cnt      current pixel column / row
//   frame_start       one-cycle pulse at start of vertical blanking
//   h_position        per-channel hook x (14 bits each, 0.1 px units)
//   v_position        per-channel hook y (14 bits each, 0.1 px units)
//   cast, cut         per-channel level requests
//   cut_v             per-channel row at which the line is cut (10 bits each)
//   vga               registered pixel colour (2 cycles after h_cnt/v_cnt)
//   background        1 = no sprite on this pixel
//   pix_valid         valid aligned with vga
//   line_state        per-channel line FSM state (2 bits each)
//
// Line FSM states:
//   state | meaning
//   IDLE  | no line drawn, waiting for cast
//   CAST  | line drawn from LINE_TOP down to the hook
//   CUT   | line drawn down to line_end, shortened each frame
module hook_renderer #(
    parameter int          NUM_HOOKS    = 2,
    parameter int          LINE_X0      = 279,
    parameter int          LINE_PITCH   = 40,
    parameter int          LINE_TOP     = 62,
    parameter int          RETRACT_STEP = 4,
    parameter logic [11:0] HOOK_COLOR   = 12'hfff,
    parameter logic [11:0] LINE_COLOR   = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid,
    input  logic [9:0]                h_cnt,
    input  logic [9:0]                v_cnt,
    input  logic                      frame_start,
    input  logic [14*NUM_HOOKS-1:0]   h_position,
    input  logic [14*NUM_HOOKS-1:0]   v_position,
    input  logic [NUM_HOOKS-1:0]      cast,
    input  logic [NUM_HOOKS-1:0]      cut,
    input  logic [10*NUM_HOOKS-1:0]   cut_v,
    output logic [11:0]               vga,
    output logic                      background,
    output logic                      pix_valid,
    output logic [2*NUM_HOOKS-1:0]    line_state
);

    localparam int          NH        = NUM_HOOKS;
    localparam logic [9:0]  TOP       = 10'(LINE_TOP);
    localparam logic [9:0]  STEP      = 10'(RETRACT_STEP);
    localparam logic [9:0]  CUT_FLOOR = 10'(LINE_TOP + RETRACT_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAST = 2'd1,
        ST_CUT  = 2'd2
    } line_st_t;

    line_st_t   st       [NH];
    logic [9:0] px       [NH];
    logic [9:0] py       [NH];
    logic [9:0] line_end [NH];
    logic [9:0] px_next  [NH];
    logic [9:0] py_next  [NH];

    logic [NH-1:0] line_hit_c;
    logic [NH-1:0] hook_hit_c;
    logic [NH-1:0] line_hit_q;
    logic [NH-1:0] hook_hit_q;
    logic          valid_q;

    logic [11:0]   vga_c;
    logic          bg_c;

    // Truncating divide by 10; anything beyond the 10-bit pixel range pins
    // to 1023 rather than wrapping back onto the visible screen.
    function automatic logic [9:0] div10_clamp(input logic [13:0] pos);
        logic [13:0] q;
        q = pos / 14'd10;
        if (q > 14'd1023) return 10'd1023;
        return q[9:0];
    endfunction

    // Hook sprite: a triangular barb anchored at (px, py). Offsets are taken
    // as signed so pixels left of / above the anchor never alias into range.
    function automatic logic hook_pixel(input logic [9:0] h, input logic [9:0] v,
                                        input logic [9:0] x, input logic [9:0] y);
        logic signed [10:0] dx;
        logic signed [10:0] dy;
        logic               hit;
        dx  = $signed({1'b0, h}) - $signed({1'b0, x});
        dy  = $signed({1'b0, v}) - $signed({1'b0, y});
        hit = 1'b0;
        if (dx >= 11'sd0 && dx <= 11'sd6 && dy >= dx) begin
            case (dx[2:0])
                3'd0:         hit = (dy <= 11'sd9);
                3'd1, 3'd2:   hit = (dy <= 11'sd8);
                3'd3, 3'd4:   hit = (dy <= 11'sd7);
                3'd5, 3'd6:   hit = (dy <= 11'sd6);
                default:      hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < NH; i++) begin
            px_next[i] = div10_clamp(h_position[14*i +: 14]);
            py_next[i] = div10_clamp(v_position[14*i +: 14]);
        end
    end

    // Shadow latch and line FSMs: everything here moves only on frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NH; i++) begin
                st[i]       <= ST_IDLE;
                px[i]       <= '0;
                py[i]       <= '0;
                line_end[i] <= '0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NH; i++) begin
                px[i] <= px_next[i];
                py[i] <= py_next[i];
                case (st[i])
                    ST_IDLE: begin
                        if (cast[i]) st[i] <= ST_CAST;
                    end
                    ST_CAST: begin
                        if (cut[i]) begin
                            st[i] <= ST_CUT;
                            // Cut point cannot lie below the hook being latched now.
                            line_end[i] <= (cut_v[10*i +: 10] < py_next[i]) ?
                                           cut_v[10*i +: 10] : py_next[i];
                        end else if (!cast[i]) begin
                            st[i] <= ST_IDLE;
                        end
                    end
                    ST_CUT: begin
                        if (line_end[i] <= CUT_FLOOR) st[i] <= ST_IDLE;
                        else                          line_end[i] <= line_end[i] - STEP;
                    end
                    default: st[i] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        line_state = '0;
        for (int i = 0; i < NH; i++) line_state[2*i +: 2] = st[i];
    end

    // Stage 1: per-channel hit detection.
    always_comb begin
        line_hit_c = '0;
        hook_hit_c = '0;
        for (int i = 0; i < NH; i++) begin
            logic [9:0] row_end;
            logic       drawn;
            row_end = (st[i] == ST_CAST) ? py[i] : line_end[i];
            drawn   = (st[i] == ST_CAST) || (st[i] == ST_CUT);
            line_hit_c[i] = valid && drawn &&
                            (h_cnt == 10'(LINE_X0 + i*LINE_PITCH)) &&
                            (v_cnt >= TOP) && (v_cnt <= row_end);
            hook_hit_c[i] = valid && hook_pixel(h_cnt, v_cnt, px[i], py[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_hit_q <= '0;
            hook_hit_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            line_hit_q <= line_hit_c;
            hook_hit_q <= hook_hit_c;
            valid_q    <= valid;
        end
    end

    // Stage 2: lowest channel wins; scanning downward lets it overwrite last.
    always_comb begin
        vga_c = 12'h000;
        bg_c  = 1'b1;
        for (int i = NH-1; i >= 0; i--) begin
            if (line_hit_q[i] || hook_hit_q[i]) begin
                bg_c  = 1'b0;
                vga_c = line_hit_q[i] ? LINE_COLOR : HOOK_COLOR;
            end
        end
        if (!valid_q) begin
            vga_c = 12'h000;
            bg_c  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga        <= 12'h000;
            background <= 1'b1;
            pix_valid  <= 1'b0;
        end else begin
            vga        <= vga_c;
            background <= bg_c;
            pix_valid  <= valid_q;
        end
    end

endmodule

// File: doc/hook_renderer.md
# hook_renderer

Parametrised, pipelined successor to the single-hook pixel colouring logic. It renders `NUM_HOOKS` independent fishing hooks, each with a line that is animated frame by frame. Inputs are the VGA pixel counters and per-channel hook positions (in 0.1-pixel units). Outputs are a registered 12-bit colour plus a `background` flag, which the downstream scene mixer uses to select the backdrop image. Positions and line state change only at frame boundaries, so a frame is never drawn with mixed positions.

## Interface
Parameters:
- `NUM_HOOKS`, 2: number of hook/line channels (1–4).
- `LINE_X0`, 279: pixel column of channel 0's line.
- `LINE_PITCH`, 40: column spacing between successive channels' lines.
- `LINE_TOP`, 62: first row of every line.
- `RETRACT_STEP`, 4: rows removed from a cut line per frame.
- `HOOK_COLOR`, 12'hfff: hook pixel colour.
- `LINE_COLOR`, 12'h000: line pixel colour.

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: synchronous, active-high reset.
- `valid`, in, 1: active-video qualifier for `h_cnt`/`v_cnt`.
- `h_cnt`, in, 10: pixel column.
- `v_cnt`, in, 10: pixel row.
- `frame_start`, in, 1: one-cycle pulse at start of vertical blanking.
- `h_position`, in, 14·NUM_HOOKS: hook x per channel, 0.1 px units; channel i occupies bits [14i+13:14i].
- `v_position`, in, 14·NUM_HOOKS: hook y per channel, same packing.
- `cast`, in, NUM_HOOKS: level; request line deployed.
- `cut`, in, NUM_HOOKS: level; request line cut.
- `cut_v`, in, 10·NUM_HOOKS: row at which the line is cut.
- `vga`, out, 12: pixel colour.
- `background`, out, 1: 1 = no sprite here.
- `pix_valid`, out, 1: `valid` delayed to align with `vga`.
- `line_state`, out, 2·NUM_HOOKS: per-channel FSM state (0 IDLE, 1 CAST, 2 CUT).

## Operation
- **Shadow latch.** On `frame_start`, each channel latches:
  - `px = h_position/10` and `py = v_position/10`, truncating division.
  - Any quotient of 1024 or more clamps to 1023.
  - Between pulses, the pixel logic uses only these latched values.
- **Per-channel FSM.** Evaluated only on `frame_start`:
  - IDLE → CAST if `cast`=1.
  - CAST → CUT if `cut`=1. On entry, load `line_end = min(cut_v, py)`. `cut` takes priority over `cast`=0.
  - CAST → IDLE if `cast`=0 and `cut`=0.
  - CUT: `line_end -= RETRACT_STEP`. If the pre-decrement `line_end` is ≤ `LINE_TOP + RETRACT_STEP`, go to IDLE instead. `cast` and `cut` are ignored in CUT.
  - The encoding value 3 is illegal and recovers to IDLE.
- **Line pixel.** Requires `h_cnt == LINE_X0 + i·LINE_PITCH` and `LINE_TOP ≤ v_cnt ≤ end`, inclusive.
  - `end` is `py` in CAST and `line_end` in CUT.
  - No line is drawn in IDLE.
- **Hook pixel.** The hook is drawn in every state. Compute `dx = h_cnt − px` and `dy = v_cnt − py` as 11-bit signed values; a pixel is a hook pixel iff dx is in 0..6 and dy is in the row range for that dx:

  | dx | dy range |
  |---|---|
  | 0 | 0..9 |
  | 1 | 1..8 |
  | 2 | 2..8 |
  | 3 | 3..7 |
  | 4 | 4..7 |
  | 5 | 5..6 |
  | 6 | 6 |

  Negative dx or dy is never a hit; no unsigned wrap.
- **Priority.**
  - The lowest channel index with any hit wins.
  - Within a channel, a line hit beats a hook hit.
  - Winner: `vga` = that colour, `background` = 0.
  - No hit, or `valid` = 0: `vga` = 12'h000, `background` = 1.

## Timing
- 2-stage pipeline:
  - Stage 1 registers the per-channel hit vectors.
  - Stage 2 registers the priority result.
  - Inputs in cycle t appear on `vga`/`background`/`pix_valid` in cycle t+2.
- Latch and FSM updates take effect the cycle after `frame_start`. A pixel presented in the same cycle as `frame_start` uses the old values.
- `line_state` is registered and changes the cycle after `frame_start`.
- Reset values:
  - `vga` = 0, `background` = 1, `pix_valid` = 0.
  - All FSMs IDLE, `px`/`py`/`line_end` = 0.
  - Pipeline registers flushed.
  - Reset mid-frame takes effect the next cycle: the outputs show background for 2 cycles, then resume with latched position 0 until the next `frame_start`.
- `cut` and `cast` held high across several frames act once per `frame_start`, as levels.

## Test plan
- **Basic hook.** Reset, then ch0 `h_position`=1000, `v_position`=2005, `frame_start`. Pixel (100,200) gives `vga`=fff and `bg`=0 two cycles later; (106,206) gives fff; (106,207) gives bg=1; (99,200) gives bg=1.
- **Cast line.** `cast`=1 at `frame_start` with `py`=150. Pixel (279,62) and pixel (279,150) give 000 with bg=0; (279,151) gives bg=1; `line_state[1:0]` = 1.
- **Cut and retract.** In CAST, `cut`=1 with `cut_v`=100. The line ends at 100, then 96, 92, … on successive frames. The FSM returns to IDLE when `line_end` ≤ 66 would be decremented, and the line then disappears.
- **Channel priority.** `NUM_HOOKS`=2 with both hooks at (100,200). The ch0 colour wins. Then ch1's line at x=319 overlapping ch0's hook: the ch0 hook wins.
- **Tearing guard.** Change `h_position` mid-frame: output is unchanged until the cycle after the next `frame_start`.
- **Reset/edges.** Assert `rst` mid-frame: the outputs show bg=1 and `pix_valid`=0 for 2 cycles. `h_position`=16383 clamps `px` to 1023, with no hook visible in columns 0–639.
